// File: rtl/instruction_fetch_unit.sv
// Purpose : instruction fetch stage; drives the instruction memory and registers
//           fetched words into IF_* for the IF/ID stage.
// Latency : one cycle from memory response to IF_* (registered); one instr/cycle sustained.
// Backpressure: stall holds IF_*; a response taken during stall is parked in a one-word
//           buffer (HOLD, no memory read). imem_busywait freezes the request address.
// Ports   : clk, rst_n (async, active-low); stall, branch_taken, branch_target from the
//           pipeline; imem_address/imem_read/imem_readdata/imem_busywait to memory;
//           if_pc, if_instruction, if_pc_plus4, if_valid to IF/ID.
// Option  : FETCH_ALIGN_CHECK_EN adds fetch_misaligned; a misaligned branch target
//           halts fetching until reset. Without it target bits [1:0] are dropped.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;   // address of the abandoned in-flight request
    logic [31:0] hold_buf, hold_buf_nxt;       // word captured while decode was stalled
    logic [31:0] if_pc_nxt, if_instr_nxt, if_plus4_nxt;
    logic        if_valid_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        halted;
    logic        bad_target;

    assign pc_plus4       = pc + 32'd4;    // natural modulo-2^32 wrap
    assign target_aligned = {branch_target[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misaligned <= 1'b0;
        else if (branch_taken && (branch_target[1:0] != 2'b00))
            misaligned <= 1'b1;
    end

    assign fetch_misaligned = misaligned;
    assign halted           = misaligned;
    assign bad_target       = (branch_target[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^branch_target[1:0];
    assign halted             = 1'b0;
    assign bad_target         = 1'b0;
`endif

    // HOLD already owns its word, so no new request is issued there.
    assign imem_read    = (state != HOLD) && !halted;
    assign imem_address = (state == DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            drain_addr     <= 32'h00000000;
            hold_buf       <= 32'h00000000;
            if_pc          <= 32'h00000000;
            if_instruction <= NOP;
            if_pc_plus4    <= 32'h00000000;
            if_valid       <= 1'b0;
        end else begin
            pc             <= pc_nxt;
            drain_addr     <= drain_addr_nxt;
            hold_buf       <= hold_buf_nxt;
            if_pc          <= if_pc_nxt;
            if_instruction <= if_instr_nxt;
            if_pc_plus4    <= if_plus4_nxt;
            if_valid       <= if_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        hold_buf_nxt   = hold_buf;
        if_pc_nxt      = if_pc;
        if_instr_nxt   = if_instruction;
        if_plus4_nxt   = if_pc_plus4;
        if_valid_nxt   = if_valid;

        if (halted) begin
            // frozen until reset
        end else if (branch_taken) begin
            // Redirect beats stall and any response arriving this cycle.
            pc_nxt       = target_aligned;
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP;
            hold_buf_nxt = 32'h00000000;
            state_nxt    = FETCH;
            if (!bad_target && (state != HOLD) && imem_busywait) begin
                // A request is still outstanding at the old address: let it finish.
                state_nxt = DRAIN;
                if (state == FETCH)
                    drain_addr_nxt = pc;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_busywait) begin
                        if (!stall) begin
                            if_pc_nxt    = pc;
                            if_instr_nxt = imem_readdata;
                            if_plus4_nxt = pc_plus4;
                            if_valid_nxt = 1'b1;
                            pc_nxt       = pc_plus4;
                        end else begin
                            hold_buf_nxt = imem_readdata;
                            state_nxt    = HOLD;
                        end
                    end else if (!stall) begin
                        if_valid_nxt = 1'b0;
                        if_instr_nxt = NOP;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        // pc is unchanged while holding, so it is the buffered word's address
                        if_pc_nxt    = pc;
                        if_instr_nxt = hold_buf;
                        if_plus4_nxt = pc_plus4;
                        if_valid_nxt = 1'b1;
                        pc_nxt       = pc_plus4;
                        state_nxt    = FETCH;
                    end
                end
                DRAIN: begin
                    // The stale response is dropped; IF_* already show a bubble.
                    if (!imem_busywait)
                        state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, imem_busywait;
    logic [31:0] branch_target;
    logic [31:0] imem_address, imem_readdata;
    logic        imem_read;
    logic [31:0] if_pc, if_instruction, if_pc_plus4;
    logic        if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misaligned;
    logic        misaligned2;
`endif

    // second instance: wrap-around reset PC, free running
    logic        stall2 = 1'b0, br2 = 1'b0, busy2 = 1'b0;
    logic [31:0] tgt2 = 32'h0;
    logic [31:0] addr2, rdata2, if_pc2, if_instr2, if_plus4_2;
    logic        read2, if_valid2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD0000;
    endfunction

    always_comb imem_readdata = mem_word(imem_address);
    always_comb rdata2        = mem_word(addr2);

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_address(imem_address), .imem_read(imem_read),
        .imem_readdata(imem_readdata), .imem_busywait(imem_busywait), .if_pc(if_pc),
        .if_instruction(if_instruction), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_misaligned(misaligned)
`endif
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .stall(stall2), .branch_taken(br2),
        .branch_target(tgt2), .imem_address(addr2), .imem_read(read2),
        .imem_readdata(rdata2), .imem_busywait(busy2), .if_pc(if_pc2),
        .if_instruction(if_instr2), .if_pc_plus4(if_plus4_2), .if_valid(if_valid2)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_misaligned(misaligned2)
`endif
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        busy;
        logic [31:0] exp_addr;   // imem_address before the edge
        logic        exp_read;   // imem_read before the edge
        logic        fire;       // a new valid instruction from exp_addr appears after the edge
        logic        exp_valid;  // if_valid after the edge
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic bw,
                       input logic [31:0] a, input logic rd, input logic f, input logic v);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.busy = bw;
        r.exp_addr = a; r.exp_read = rd; r.fire = f; r.exp_valid = v;
        vecs.push_back(r);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pop(input string name);
        logic [31:0] p;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got if_pc %h", name, if_pc);
        end else begin
            p = exp_q.pop_front();
            check32({name, "_pc"}, if_pc, p);
            check32({name, "_instr"}, if_instruction, mem_word(p));
            check32({name, "_plus4"}, if_pc_plus4, p + 32'd4);
            last_pc = p;
        end
    endtask

    initial begin
        // sequential fetch 0..C, then busywait bubbles at 0x10
        add(0,0,0,0, 32'h000,1,1,1);
        add(0,0,0,0, 32'h004,1,1,1);
        add(0,0,0,0, 32'h008,1,1,1);
        add(0,0,0,0, 32'h00C,1,1,1);
        add(0,0,0,1, 32'h010,1,0,0);
        add(0,0,0,1, 32'h010,1,0,0);
        add(0,0,0,1, 32'h010,1,0,0);
        add(0,0,0,0, 32'h010,1,1,1);
        add(0,0,0,0, 32'h014,1,1,1);
        add(0,0,0,0, 32'h018,1,1,1);
        add(0,0,0,0, 32'h01C,1,1,1);
        // stall while 0x20 answers -> HOLD
        add(1,0,0,0, 32'h020,1,0,1);
        add(1,0,0,0, 32'h020,0,0,1);
        add(0,0,0,0, 32'h020,0,1,1);
        for (int a = 32'h24; a <= 32'h3C; a += 4) add(0,0,0,0, 32'(a),1,1,1);
        // branch to 0x100 while 0x40 busy -> DRAIN
        add(0,0,0,1, 32'h040,1,0,0);
        add(0,1,32'h100,1, 32'h040,1,0,0);
        add(0,0,0,1, 32'h040,1,0,0);
        add(0,0,0,0, 32'h040,1,0,0);
        add(0,0,0,0, 32'h100,1,1,1);
        add(0,0,0,0, 32'h104,1,1,1);
        // retarget during DRAIN
        add(0,1,32'h200,1, 32'h108,1,0,0);
        add(0,1,32'h300,1, 32'h108,1,0,0);
        add(0,0,0,0, 32'h108,1,0,0);
        add(0,0,0,0, 32'h300,1,1,1);
        // branch while in HOLD discards the buffer
        add(1,0,0,0, 32'h304,1,0,1);
        add(1,1,32'h400,0, 32'h304,0,0,0);
        add(0,0,0,0, 32'h400,1,1,1);
        // stall with busywait: hold valid, then bubble, then hold the bubble
        add(1,0,0,1, 32'h404,1,0,1);
        add(0,0,0,1, 32'h404,1,0,0);
        add(1,0,0,1, 32'h404,1,0,0);
        add(0,0,0,0, 32'h404,1,1,1);
        // branch beats stall and response
        add(1,1,32'h500,0, 32'h408,1,0,0);
        add(0,0,0,0, 32'h500,1,1,1);
        // misaligned target
        add(0,1,32'h102,0, 32'h504,1,0,0);
`ifdef FETCH_ALIGN_CHECK_EN
        add(0,0,0,0, 32'h100,0,0,0);
`else
        add(0,0,0,0, 32'h100,1,1,1);
`endif

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_busywait = 1'b0; last_pc = 32'h0;
        repeat (2) @(negedge clk);
        check32("rst_if_pc", if_pc, 32'h0);
        check32("rst_if_plus4", if_pc_plus4, 32'h0);
        check32("rst_if_instr", if_instruction, NOP);
        check32("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check32("rst_addr", imem_address, 32'h0);
        check32("rst_read", {31'b0, imem_read}, 32'h1);
        check32("rst2_addr", addr2, 32'hFFFFFFFC);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            check32($sformatf("addr[%0d]", i), imem_address, vecs[i].exp_addr);
            check32($sformatf("read[%0d]", i), {31'b0, imem_read}, {31'b0, vecs[i].exp_read});
            stall         = vecs[i].stall;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_busywait = vecs[i].busy;
            if (vecs[i].fire) exp_q.push_back(vecs[i].exp_addr);
            @(negedge clk);
            check32($sformatf("valid[%0d]", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].fire)
                check_pop($sformatf("sb[%0d]", i));
            else if (vecs[i].exp_valid)
                check32($sformatf("hold_pc[%0d]", i), if_pc, last_pc);
            else
                check32($sformatf("nop[%0d]", i), if_instruction, NOP);
            if (i == 0) begin
                check32("wrap_if_pc", if_pc2, 32'hFFFFFFFC);
                check32("wrap_if_plus4", if_plus4_2, 32'h0);
                check32("wrap_next_addr", addr2, 32'h0);
                check32("wrap_valid", {31'b0, if_valid2}, 32'h1);
            end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        check32("misaligned_flag", {31'b0, misaligned}, 32'h1);
`endif

        // reset asserted in the middle of a busy request
        stall = 1'b0; branch_taken = 1'b0; imem_busywait = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check32("midrst_addr", imem_address, 32'h0);
        check32("midrst_read", {31'b0, imem_read}, 32'h1);
        check32("midrst_valid", {31'b0, if_valid}, 32'h0);
        check32("midrst_instr", if_instruction, NOP);
        check32("midrst_if_pc", if_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check32("midrst_misaligned", {31'b0, misaligned}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        imem_busywait = 1'b0;
        check32("post_rst_addr", imem_address, 32'h0);
        check32("post_rst_read", {31'b0, imem_read}, 32'h1);
        exp_q.push_back(32'h0);
        @(negedge clk);
        check32("post_rst_valid", {31'b0, if_valid}, 32'h1);
        check_pop("post_rst_sb");

        check32("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, fetch address loaded on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 STALL  input  1  hazard stall from decode; IF_* outputs shall hold while high.
REQ-005 BRANCH_TAKEN  input  1  redirect request from execute.
REQ-006 BRANCH_TARGET  input  32  redirect address.
REQ-007 IMEM_ADDRESS  output  32  instruction memory address.
REQ-008 IMEM_READ  output  1  instruction memory read request.
REQ-009 IMEM_READDATA  input  32  instruction word, valid in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
REQ-010 IMEM_BUSYWAIT  input  1  memory not ready; request shall be held stable while high.
REQ-011 IF_PC, IF_INSTRUCTION, IF_PC_PLUS4  output  32 each  registered fetch results feeding the IF/ID stage register.
REQ-012 IF_VALID  output  1  IF_* carry a real instruction; low means bubble.
REQ-013 FETCH_MISALIGNED  output  1  sticky misaligned-target flag (present only under FETCH_ALIGN_CHECK_EN).

Function
REQ-014 Internal PC register; IMEM_ADDRESS shall equal PC in FETCH and DRAIN-free cycles, and the old address in DRAIN.
REQ-015 States: FETCH (IMEM_READ=1), HOLD (IMEM_READ=0, one fetched word buffered), DRAIN (IMEM_READ=1, old address, response discarded).
REQ-016 FETCH, response (BUSYWAIT=0), STALL=0: next edge IF_PC<=PC, IF_INSTRUCTION<=IMEM_READDATA, IF_PC_PLUS4<=PC+4, IF_VALID<=1, PC<=PC+4, stay FETCH.
REQ-017 FETCH, response, STALL=1: word and PC captured to buffer, IF_* held, go HOLD.
REQ-018 FETCH, no response, STALL=0: IF_VALID<=0, IF_INSTRUCTION<=32'h00000013 (NOP), IF_PC/IF_PC_PLUS4 held.
REQ-019 Any state, STALL=1 and no BRANCH_TAKEN: IF_* and IF_VALID shall hold unchanged.
REQ-020 HOLD, STALL=0: buffer presented on IF_* with IF_VALID<=1, PC<=PC+4, go FETCH.
REQ-021 Sustained throughput one instruction per cycle when BUSYWAIT=0 and STALL=0.
REQ-022 BRANCH_TAKEN has priority over STALL and any response: PC<=BRANCH_TARGET, IF_VALID<=0, IF_INSTRUCTION<=NOP, HOLD buffer discarded.
REQ-023 BRANCH_TAKEN in FETCH with BUSYWAIT=1: go DRAIN; leave DRAIN to FETCH on first cycle with BUSYWAIT=0, that response discarded.
REQ-024 BRANCH_TAKEN during DRAIN: PC updated to newest target, remain DRAIN.
REQ-025 PC+4 shall wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), both for PC and IF_PC_PLUS4.

Reset
REQ-026 RST_N low shall immediately force PC=RESET_PC, state FETCH, IF_PC=0, IF_PC_PLUS4=0, IF_INSTRUCTION=32'h00000013, IF_VALID=0, FETCH_MISALIGNED=0, buffer cleared.
REQ-027 Reset mid-request abandons the request; first fetch after release addresses RESET_PC with IMEM_READ=1.

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: BRANCH_TAKEN with BRANCH_TARGET[1:0]!=0 sets FETCH_MISALIGNED=1, drives IMEM_READ=0 and IF_VALID=0 until reset.
REQ-029 Macro undefined: FETCH_MISALIGNED port absent, BRANCH_TARGET[1:0] forced to 2'b00 when loaded into PC.

Verification
REQ-030 Reset release, BUSYWAIT=0, STALL=0, memory returns addr-dependent words -> IF_PC 0,4,8,12 on consecutive cycles, IF_VALID=1 each, IF_PC_PLUS4=IF_PC+4.
REQ-031 BUSYWAIT high 3 cycles at PC=0x10 -> IMEM_ADDRESS stable 0x10, 3 NOP bubbles IF_VALID=0, then IF_PC=0x10 valid.
REQ-032 STALL high 2 cycles while response for 0x20 arrives -> IF_* hold prior instruction, IMEM_READ=0 in HOLD, then IF_PC=0x20 valid, next fetch 0x24.
REQ-033 BRANCH_TAKEN target 0x100 while BUSYWAIT=1 at 0x40 -> DRAIN, 0x40 data never appears on IF_*, next valid IF_PC=0x100.
REQ-034 RESET_PC=32'hFFFFFFFC -> IF_PC_PLUS4=0, next fetch address 0; misaligned target 0x102 -> FETCH_MISALIGNED=1 with macro, PC=0x100 without.
